// File: rtl/alu_pkg.sv
// Op-codes and FSM encoding shared by the multi-cycle ALU.
// Op-codes match the control unit's 3-bit op field.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_multiciclo_if.sv
// operar/listo handshake and data bus between control unit and ALU.
interface alu_multiciclo_if #(
    parameter int N = 16
);
    logic         operar;
    logic [2:0]   op;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [N-1:0] out;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         listo;
    logic         ocupado;

    modport master (
        output operar, op, in_a, in_b,
        input  out, z, n, c, v, listo, ocupado
    );

    modport slave (
        input  operar, op, in_a, in_b,
        output out, z, n, c, v, listo, ocupado
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// prod is the accumulator value after the current step.
module alu_mul_iter #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           fin,
    output logic [2*N-1:0] prod
);
    localparam int CW = $clog2(N);

    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  count;

    assign prod = mplier[0] ? acc + mcand : acc;
    assign fin  = (count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= {{N{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            count  <= '0;
        end else if (step) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end
endmodule

// File: rtl/alu_multiciclo.sv
// Registered ALU: single-cycle ops complete in one clock, MUL iterates N.
// out and flags only move on reset or when an op completes.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_multiciclo_if.slave bus
);
    state_t         state;
    logic [N-1:0]   out_q;
    logic           z_q, n_q, c_q, v_q;
    logic           listo_q, ocupado_q;

    logic           accept, is_mul, mul_fin;
    logic [2*N-1:0] mul_prod;
    logic [N:0]     sum, dif;
    logic [N-1:0]   a, b, res;
    logic           rc, rv;

    assign a      = bus.in_a;
    assign b      = bus.in_b;
    assign accept = (state == ST_IDLE) && bus.operar;
    assign is_mul = (bus.op == OP_MUL);

    alu_mul_iter #(.N(N)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_mul),
        .step  (state == ST_MUL),
        .a     (a),
        .b     (b),
        .fin   (mul_fin),
        .prod  (mul_prod)
    );

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    // Carry/borrow comes from bit N of the widened add/sub.
    always_comb begin
        res = '0;
        rc  = 1'b0;
        rv  = 1'b0;
        unique case (1'b1)
            (bus.op == OP_ADD): begin
                res = sum[N-1:0];
                rc  = sum[N];
                rv  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            (bus.op == OP_SUB): begin
                res = dif[N-1:0];
                rc  = dif[N];
                rv  = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            (bus.op == OP_ASR): begin
                res = {a[N-1], a[N-1:1]};
                rc  = a[0];
            end
            (bus.op == OP_AND): res = a & b;
            (bus.op == OP_OR):  res = a | b;
            (bus.op == OP_XOR): res = a ^ b;
            (bus.op == OP_SHL): begin
                res = {a[N-2:0], 1'b0};
                rc  = a[N-1];
            end
            (bus.op == OP_MUL): res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_q     <= '0;
            z_q       <= 1'b1;
            n_q       <= 1'b0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.operar && is_mul) begin
                        state     <= ST_MUL;
                        ocupado_q <= 1'b1;
                    end else if (bus.operar) begin
                        out_q   <= res;
                        z_q     <= (res == '0);
                        n_q     <= res[N-1];
                        c_q     <= rc;
                        v_q     <= rv;
                        listo_q <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (mul_fin) begin
                        state     <= ST_IDLE;
                        ocupado_q <= 1'b0;
                        out_q     <= mul_prod[N-1:0];
                        z_q       <= (mul_prod[N-1:0] == '0);
                        n_q       <= mul_prod[N-1];
                        c_q       <= |mul_prod[2*N-1:N];
                        v_q       <= 1'b0;
                        listo_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.out     = out_q;
    assign bus.z       = z_q;
    assign bus.n       = n_q;
    assign bus.c       = c_q;
    assign bus.v       = v_q;
    assign bus.listo   = listo_q;
    assign bus.ocupado = ocupado_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: vector table, MUL sequences,
// hold and mid-multiply reset, with a scoreboard queue popped on listo.
module tb_alu_multiciclo;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        z, n, c, v;
    } vec_t;

    typedef struct {
        logic [15:0] r;
        logic        z, n, c, v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_multiciclo_if #(.N(16)) bus ();

    alu_multiciclo #(.N(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t last;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   run      = 0;
    int   last_run = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every listo pulse must match the oldest pending result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.listo) begin
            run++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_listo: got out=%h, none pending",
                         bus.out);
            end else begin
                e = sb.pop_front();
                chk("out", 32'(bus.out), 32'(e.r));
                chk("flags_znvc", {28'd0, bus.z, bus.n, bus.c, bus.v},
                    {28'd0, e.z, e.n, e.c, e.v});
                last = e;
            end
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic issue(logic [2:0] op, logic [15:0] a, logic [15:0] b);
        @(negedge clk);
        bus.operar = 1'b1;
        bus.op     = op;
        bus.in_a   = a;
        bus.in_b   = b;
    endtask

    task automatic push(logic [15:0] r, logic z, logic n, logic c, logic v);
        exp_t e;
        e.r = r; e.z = z; e.n = n; e.c = c; e.v = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic mul_run(logic [15:0] a, logic [15:0] b, logic [15:0] r,
                           logic c);
        int  cnt;
        bit  done;
        cnt  = 0;
        done = 0;
        issue(OP_MUL, a, b);
        push(r, r == 16'h0, r[15], c, 1'b0);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.operar = 1'b1;
                bus.op     = OP_ADD;
            end else begin
                bus.operar = 1'b0;
            end
            bus.in_a = 16'($urandom);
            bus.in_b = 16'($urandom);
            if (bus.ocupado) cnt++;
            if (bus.listo) begin
                done = 1;
                chk("ocupado_at_listo", 32'(bus.ocupado), 32'd0);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL mul_timeout: got no listo, expected one");
        end
        chk("ocupado_cycles", 32'(cnt), 32'd16);
        @(negedge clk);
        chk("listo_pulse", 32'(bus.listo), 32'd0);
        drain();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{OP_ADD, 16'd10,   16'd5,    16'd15,   0, 0, 0, 0};
        vecs[1]  = '{OP_SUB, 16'd10,   16'd5,    16'd5,    0, 0, 0, 0};
        vecs[2]  = '{OP_AND, 16'd10,   16'd5,    16'd0,    1, 0, 0, 0};
        vecs[3]  = '{OP_ASR, 16'hFFF6, 16'h0,    16'hFFFB, 0, 1, 0, 0};
        vecs[4]  = '{OP_SHL, 16'hFFF6, 16'h0,    16'hFFEC, 0, 1, 1, 0};
        vecs[5]  = '{OP_ADD, 16'h7FFF, 16'h1,    16'h8000, 0, 1, 0, 1};
        vecs[6]  = '{OP_SUB, 16'h0,    16'h1,    16'hFFFF, 0, 1, 1, 0};
        vecs[7]  = '{OP_OR,  16'h00F0, 16'h0F0F, 16'h0FFF, 0, 0, 0, 0};
        vecs[8]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0,    1, 0, 0, 0};
        vecs[9]  = '{OP_ADD, 16'hFFFF, 16'h1,    16'h0,    1, 0, 1, 0};
        vecs[10] = '{OP_SUB, 16'h8000, 16'h1,    16'h7FFF, 0, 0, 0, 1};
        vecs[11] = '{OP_ASR, 16'h0001, 16'h0,    16'h0,    1, 0, 1, 0};
        vecs[12] = '{OP_SHL, 16'h4000, 16'h0,    16'h8000, 0, 1, 0, 0};

        bus.operar = 1'b0;
        bus.op     = OP_ADD;
        bus.in_a   = '0;
        bus.in_b   = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_flags_znvc", {28'd0, bus.z, bus.n, bus.c, bus.v}, 32'h8);
        chk("rst_listo", 32'(bus.listo), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        rst = 1'b0;

        // Back-to-back table ops: one per clock.
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            push(vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
        end
        @(negedge clk);
        bus.operar = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("listo_run", 32'(last_run), 32'd13);

        // operar low: outputs hold while op and operands move.
        for (int k = 0; k < 3; k++) begin
            bus.op   = 3'(k);
            bus.in_a = 16'h1234 + 16'(k);
            bus.in_b = 16'h0F0F;
            @(negedge clk);
            chk("hold_out", 32'(bus.out), 32'(last.r));
            chk("hold_flags", {28'd0, bus.z, bus.n, bus.c, bus.v},
                {28'd0, last.z, last.n, last.c, last.v});
            chk("hold_listo", 32'(bus.listo), 32'd0);
        end

        mul_run(16'd300, 16'd300, 16'h5F90, 1'b1);
        mul_run(16'd3, 16'd7, 16'd21, 1'b0);
        mul_run(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);

        // Reset on the fifth cycle of a multiply aborts it.
        issue(OP_MUL, 16'd300, 16'd300);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.operar = 1'b0;
            if (i == 4) rst = 1'b1;
            if (i == 5) begin
                rst = 1'b0;
                chk("abort_out", 32'(bus.out), 32'd0);
                chk("abort_z", 32'(bus.z), 32'd1);
                chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
                chk("abort_listo", 32'(bus.listo), 32'd0);
            end
        end
        repeat (20) @(negedge clk);
        issue(OP_ADD, 16'd2, 16'd3);
        push(16'd5, 0, 0, 0, 0);
        @(negedge clk);
        bus.operar = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end
endmodule
